// File: rtl/systolic_array_4x4.sv
// 4x4 output-stationary MAC array fed by skewed A-row / B-column streams.
// A small IDLE/RUN/DONE controller clears the array on start and flags when C is final.
module systolic_array_4x4 #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32,
    parameter int K      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a0,
    input  logic [DATA_W-1:0]     a1,
    input  logic [DATA_W-1:0]     a2,
    input  logic [DATA_W-1:0]     a3,
    input  logic [DATA_W-1:0]     b0,
    input  logic [DATA_W-1:0]     b1,
    input  logic [DATA_W-1:0]     b2,
    input  logic [DATA_W-1:0]     b3,
    output logic                  busy,
    output logic                  done,
    output logic [16*ACC_W-1:0]   c_flat
);

    localparam int LAST  = K + 6;
    localparam int CNT_W = $clog2(LAST + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               clear;
    logic [CNT_W-1:0]   cnt;

    logic [DATA_W-1:0]  a_edge [4];
    logic [DATA_W-1:0]  b_edge [4];
    logic [DATA_W-1:0]  a_in   [4][4];
    logic [DATA_W-1:0]  b_in   [4][4];
    logic [DATA_W-1:0]  a_reg  [4][4];
    logic [DATA_W-1:0]  b_reg  [4][4];
    logic [ACC_W-1:0]   acc    [4][4];

    assign a_edge[0] = a0;
    assign a_edge[1] = a1;
    assign a_edge[2] = a2;
    assign a_edge[3] = a3;
    assign b_edge[0] = b0;
    assign b_edge[1] = b1;
    assign b_edge[2] = b2;
    assign b_edge[3] = b3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The counter reads 0 in the first RUN cycle, so the final MAC of PE(3,3)
    // happens while it reads K+5; leaving RUN then puts done in cycle K+7.
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(LAST - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    for (genvar i = 0; i < 4; i++) begin : g_row
        for (genvar j = 0; j < 4; j++) begin : g_col
            logic [2*DATA_W-1:0] prod;

            if (j == 0) begin : g_a_edge
                assign a_in[i][j] = a_edge[i];
            end else begin : g_a_hop
                assign a_in[i][j] = a_reg[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_in[i][j] = b_edge[j];
            end else begin : g_b_hop
                assign b_in[i][j] = b_reg[i-1][j];
            end

            assign prod = a_in[i][j] * b_in[i][j];

            // Forwarding registers always shift; only the accumulator is gated to RUN.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                    acc[i][j]   <= '0;
                end else if (clear) begin
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                    acc[i][j]   <= '0;
                end else begin
                    a_reg[i][j] <= a_in[i][j];
                    b_reg[i][j] <= b_in[i][j];
                    if (state == RUN) begin
                        acc[i][j] <= acc[i][j] + ACC_W'(prod);
                    end
                end
            end

            assign c_flat[(4*i+j)*ACC_W +: ACC_W] = acc[i][j];
        end
    end

endmodule

// File: doc/systolic_array_4x4.md
Name: systolic_array_4x4

Overview:
- 4x4 output-stationary MAC array; the downstream consumer of the skewed row stream of matrix A and the matching column stream of matrix B.
- Row i of A enters on a_i, delayed i cycles and zero-padded. Column j of B enters on b_j the same way.
- Each PE(i,j) accumulates C[i][j] = sum over k of A[i][k]*B[k][j].
- A small controller clears accumulators on start, tracks progress and flags when C is final.

Parameters:
- DATA_W, 32, width of each a_i / b_j operand.
- ACC_W, 32, width of each accumulator and C element.
- K, 4, inner dimension, i.e. number of valid elements per row/column stream (K >= 1).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- start  input  1  one-cycle pulse, same cycle the feeders assert their read enable
- a0..a3  input  DATA_W each  skewed A row streams; zero when not valid
- b0..b3  input  DATA_W each  skewed B column streams; zero when not valid
- busy  output  1  high while a computation is in progress
- done  output  1  one-cycle pulse: C is final
- c_flat  output  16*ACC_W  C[i][j] at bits [(4i+j)*ACC_W +: ACC_W]

Behaviour:
- PE(i,j) per cycle:
  - acc <= acc + a_in*b_in.
  - a_out <= a_in; b_out <= b_in (one register per hop).
  - PE(i,0).a_in = a_i; PE(0,j).b_in = b_j; otherwise a_in/b_in come from the left/upper neighbour's registers.
- Arithmetic:
  - Product is the low ACC_W bits of the full DATA_W x DATA_W product.
  - Sum wraps modulo 2^ACC_W; no saturation, no overflow flag.
  - Two's-complement and unsigned interpretations give identical low bits.
- Timing, with start high in cycle 0:
  - A[i][k] is on a_i during cycle 1+i+k; B[k][j] is on b_j during cycle 1+j+k.
  - A[i][k] and B[k][j] meet in PE(i,j) in cycle 1+i+j+k.
  - Last MAC (PE(3,3), k=K-1) is in cycle K+6.
  - done is high in cycle K+7. With K=4: last MAC in cycle 10, done in cycle 11.
- FSM: IDLE, RUN, DONE.
  - IDLE: start -> clear all 16 acc and all forwarding registers at that edge; cycle counter := 0; go RUN.
  - RUN: counter increments each cycle; at counter == K+6 go DONE. Edge inputs keep flowing; zero-padding makes extra MACs harmless.
  - DONE: lasts one cycle; done=1. start -> behave as IDLE+start (back-to-back accepted); else go IDLE.
- busy = 1 in RUN and DONE.
- start while in RUN: ignored. No clear, no counter change.
- Output holding:
  - Accumulators are frozen outside RUN: no accumulation in IDLE or DONE.
  - c_flat stays stable from done until the next accepted start clears it.
- c_flat is driven directly from the accumulators.
- Reset: all acc, forwarding registers and the counter go to 0; state IDLE; busy=0, done=0, c_flat=0. Applies mid-RUN too, and no done follows.
- The counter is sized for K+6; it does not wrap within a run.

Test Plan:
- A = identity, B = values 1..16 row-major, skewed feeds, start at cycle 0, K=4 -> done only in cycle 11; busy cycles 1-11; c_flat equals B; idle afterwards with c_flat held.
- A = all 2, B = all 3 -> every C element = 24.
- start pulse again in cycle 5 of a run -> ignored; done still in cycle 11; results unchanged.
- start asserted in the done cycle with new data A = B = identity -> second run clears; done 11 cycles later; C = identity.
- rst_n low in cycle 6 of a run, then released -> c_flat=0, busy=0, no done; a fresh start yields correct results.
- A[0][0] = B[0][0] = 0x0001_0000, all other elements 0 -> C[0][0] = 0 (wrap); other elements 0.
